eb_downsizer: RTL and testbench
===============================

Name: eb_downsizer

Overview:
- Elastic width-down converter placed directly downstream of eb_fifo.
- Consumes one DWIDTH-wide word per handshake on its t_ side and emits it as a sequence of OWIDTH-wide beats on its i_ side.
- Carries a per-word beat count and a last-beat marker.
- Sustains full throughput: words are back-to-back with no bubble beat between them.

Parameters:
- DWIDTH, 32, input word width.
- OWIDTH, 8, output beat width. DWIDTH % OWIDTH must be 0.
- MSB_FIRST, 0, beat ordering:
  - 0: emit the least-significant slice first.
  - 1: emit the most-significant slice first.
- Derived, not overridable:
  - RATIO = DWIDTH/OWIDTH; must be at least 2.
  - CWIDTH = $clog2(RATIO).
- Elaboration error if either constraint is violated.

Ports:
- clk  input  1  clock.
- rstf  input  1  asynchronous active-low reset.
- t_data  input  DWIDTH  word from the upstream FIFO.
- t_len  input  CWIDTH  number of valid beats in the word, minus 1.
- t_valid  input  1  upstream word valid.
- t_ready  output  1  word accepted when t_valid && t_ready.
- i_data  output  OWIDTH  current beat.
- i_last  output  1  current beat is the final beat of its word.
- i_valid  output  1  beat valid.
- i_ready  input  1  beat consumed when i_valid && i_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset rstf is asynchronous, active-low.
- Reset values:
  - i_valid=0, i_last=0, i_data=0.
  - Internal word_r=0, len_r=0, beat_cnt=0, busy=0.
  - t_ready=1 after reset.
- State:
  - IDLE (busy=0): no word held.
  - SEND (busy=1): word_r held; beat_cnt indexes the current beat.
- Outputs:
  - i_valid = busy.
  - i_last = busy && (beat_cnt == len_r).
  - i_data = slice k of word_r, where slice k is bits [k*OWIDTH +: OWIDTH].
  - k = beat_cnt when MSB_FIRST=0; k = RATIO-1-beat_cnt when MSB_FIRST=1.
- Ready: t_ready = !busy || (i_valid && i_ready && i_last).
  - Combinational from i_ready; this is the only combinational input-to-output path.
- Word accept (t_valid && t_ready):
  - word_r <= t_data.
  - len_r <= min(t_len, RATIO-1). t_len values above RATIO-1 (only possible when RATIO is not a power of 2) are clamped.
  - beat_cnt <= 0; busy <= 1.
- Beat handshake (i_valid && i_ready):
  - Not last: beat_cnt <= beat_cnt+1.
  - Last and no word accepted this cycle: busy <= 0, beat_cnt <= 0.
  - Last with a simultaneous accept: the new word loads. The next cycle presents beat 0 of the new word with no bubble.
- Latency: a word accepted in cycle N presents its first beat in cycle N+1.
- Throughput: one beat per cycle while i_ready=1, across word boundaries.
- Backpressure: while i_valid && !i_ready, i_data, i_last and beat_cnt hold stable, and t_ready=0.
- t_valid while busy and not completing the last beat: no accept. The upstream FIFO holds the word.
- t_len=0: single-beat word; i_last is asserted on the first beat.
- Unused upper slices of a short word are never emitted.
- Reset mid-word: the held word is discarded. i_valid drops to 0 asynchronously. No partial beats follow after rstf deasserts.
- No internal overflow or underflow is possible; there is no error output.

Test Plan:
1. Reset check:
   - Stimulus: assert rstf=0 with t_valid=1.
   - Required: i_valid=0, i_last=0, i_data=0 throughout. After release, t_ready=1 and no beat appears until an accept.
2. Single word, MSB_FIRST=0, DWIDTH=32, OWIDTH=8:
   - Stimulus: t_data=0xAABBCCDD, t_len=3, i_ready=1.
   - Required: first beat one cycle after accept. Beats DD, CC, BB, AA on consecutive cycles, i_last only on AA. t_ready=0 on the DD/CC/BB cycles and 1 on the AA cycle.
3. Back-to-back words:
   - Stimulus: 0x03020100 then 0x07060504, t_valid continuously high, i_ready=1.
   - Required: 8 consecutive beats 00..07 with no gap. Second word accepted in the same cycle beat 03 is consumed. i_last on 03 and 07.
4. Backpressure:
   - Stimulus: word 0x11223344; i_ready low for 3 cycles on beat 2.
   - Required: i_data=0x22, i_valid=1, t_ready=0 stable for those 3 cycles. Then 0x11 with i_last.
5. Short word and MSB_FIRST:
   - Stimulus (a): MSB_FIRST=0, t_len=1, t_data=0xAABBCCDD.
   - Required (a): beats DD, CC; i_last on CC.
   - Stimulus (b): MSB_FIRST=1, t_len=3, t_data=0xAABBCCDD.
   - Required (b): beats AA, BB, CC, DD; i_last on DD.
6. Reset mid-word:
   - Stimulus: pulse rstf low after beat 1 of 0xAABBCCDD.
   - Required: i_valid falls immediately. After release, no BB or AA beat appears, and the next accepted word starts at its beat 0.

Source files
------------

// File: rtl/eb_downsizer.sv
// eb_downsizer: elastic width-down converter. Accepts one DWIDTH word per
// handshake and replays it as up to RATIO beats of OWIDTH bits, with a
// last-beat marker and no bubble between back-to-back words.
module eb_downsizer #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned OWIDTH    = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                                   clk,
  input  logic                                   rstf,
  input  logic [DWIDTH-1:0]                      t_data,
  input  logic [$clog2(DWIDTH/OWIDTH)-1:0]       t_len,
  input  logic                                   t_valid,
  output logic                                   t_ready,
  output logic [OWIDTH-1:0]                      i_data,
  output logic                                   i_last,
  output logic                                   i_valid,
  input  logic                                   i_ready
);

  localparam int unsigned RATIO  = DWIDTH / OWIDTH;
  localparam int unsigned CWIDTH = $clog2(RATIO);
  localparam logic [CWIDTH-1:0] LEN_MAX = CWIDTH'(RATIO - 1);

  if (OWIDTH == 0 || (DWIDTH % OWIDTH) != 0 || RATIO < 2) begin : g_param_check
    $error("eb_downsizer: DWIDTH must be a multiple of OWIDTH with a ratio of at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [DWIDTH-1:0]   word_r;
  logic [CWIDTH-1:0]   len_r;
  logic [CWIDTH-1:0]   beat_cnt;
  logic                busy;
  logic                last_beat;
  logic                beat_done;
  logic                accept;

  assign busy      = (state == SEND);
  assign last_beat = busy && (beat_cnt == len_r);
  assign beat_done = busy && i_ready;
  // Ready is combinational from i_ready so a new word can load in the same
  // cycle the final beat of the current word is consumed.
  assign t_ready   = !busy || (beat_done && last_beat);
  assign accept    = t_valid && t_ready;

  assign i_valid   = busy;
  assign i_last    = last_beat;

  // Select the current slice of the held word according to beat order.
  always_comb begin
    int unsigned k;
    k = 32'(beat_cnt);
    if (MSB_FIRST != 0) k = RATIO - 1 - k;
    i_data = '0;
    for (int unsigned s = 0; s < RATIO; s++) begin
      if (s == k) i_data = word_r[s*OWIDTH +: OWIDTH];
    end
  end

  // Word load / beat sequencing FSM.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state    <= IDLE;
      word_r   <= '0;
      len_r    <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      state    <= SEND;
      word_r   <= t_data;
      len_r    <= (t_len > LEN_MAX) ? LEN_MAX : t_len;
      beat_cnt <= '0;
    end else if (beat_done) begin
      if (last_beat) begin
        state    <= IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_eb_downsizer.sv
// Bench for eb_downsizer: two instances (LSB-first and MSB-first) share the
// same stimulus; a per-cycle vector table holds hand-computed expectations.
module tb_eb_downsizer;

  logic        clk;
  logic        rstf;
  logic [31:0] t_data;
  logic [1:0]  t_len;
  logic        t_valid;
  logic        i_ready;
  logic        t_ready0, t_ready1;
  logic [7:0]  i_data0, i_data1;
  logic        i_last0, i_last1;
  logic        i_valid0, i_valid1;

  int n_vec;
  int n_err;

  eb_downsizer #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rstf(rstf), .t_data(t_data), .t_len(t_len), .t_valid(t_valid),
    .t_ready(t_ready0), .i_data(i_data0), .i_last(i_last0), .i_valid(i_valid0),
    .i_ready(i_ready)
  );

  eb_downsizer #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rstf(rstf), .t_data(t_data), .t_len(t_len), .t_valid(t_valid),
    .t_ready(t_ready1), .i_data(i_data1), .i_last(i_last1), .i_valid(i_valid1),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstf;
    logic        tv;
    logic [31:0] td;
    logic [1:0]  tl;
    logic        ir;
    logic        tr;
    logic        iv;
    logic        il0;
    logic        il1;
    logic        chk_d;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic tv, logic [31:0] td, logic [1:0] tl, logic ir,
                              logic tr, logic iv, logic il0, logic il1,
                              logic chk_d, logic [7:0] d0, logic [7:0] d1);
    vec_t v;
    v.rstf = r; v.tv = tv; v.td = td; v.tl = tl; v.ir = ir;
    v.tr = tr; v.iv = iv; v.il0 = il0; v.il1 = il1;
    v.chk_d = chk_d; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, vec_t v);
    n_vec++;
    check("t_ready0", idx, 32'(t_ready0), 32'(v.tr));
    check("t_ready1", idx, 32'(t_ready1), 32'(v.tr));
    check("i_valid0", idx, 32'(i_valid0), 32'(v.iv));
    check("i_valid1", idx, 32'(i_valid1), 32'(v.iv));
    check("i_last0",  idx, 32'(i_last0),  32'(v.il0));
    check("i_last1",  idx, 32'(i_last1),  32'(v.il1));
    if (v.chk_d) begin
      check("i_data0", idx, 32'(i_data0), 32'(v.d0));
      check("i_data1", idx, 32'(i_data1), 32'(v.d1));
    end
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    rstf = 1'b0; t_valid = 1'b0; t_data = '0; t_len = '0; i_ready = 1'b1;

    //                rst tv  td            tl ir  tr iv l0 l1 cd d0     d1
    // reset with t_valid high, then idle
    vecs.push_back(mk(0, 1, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    // single full word
    vecs.push_back(mk(1, 1, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hDD, 8'hAA));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hCC, 8'hBB));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hBB, 8'hCC));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'hAA, 8'hDD));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    // back-to-back words
    vecs.push_back(mk(1, 1, 32'h03020100, 3, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 32'h07060504, 3, 1,  0, 1, 0, 0, 1, 8'h00, 8'h03));
    vecs.push_back(mk(1, 1, 32'h07060504, 3, 1,  0, 1, 0, 0, 1, 8'h01, 8'h02));
    vecs.push_back(mk(1, 1, 32'h07060504, 3, 1,  0, 1, 0, 0, 1, 8'h02, 8'h01));
    vecs.push_back(mk(1, 1, 32'h07060504, 3, 1,  1, 1, 1, 1, 1, 8'h03, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h04, 8'h07));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h05, 8'h06));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h06, 8'h05));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'h07, 8'h04));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    // backpressure on beat 2, with a competing word offered meanwhile
    vecs.push_back(mk(1, 1, 32'h11223344, 3, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h44, 8'h11));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h33, 8'h22));
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 3, 0,  0, 1, 0, 0, 1, 8'h22, 8'h33));
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 3, 0,  0, 1, 0, 0, 1, 8'h22, 8'h33));
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 3, 0,  0, 1, 0, 0, 1, 8'h22, 8'h33));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h22, 8'h33));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'h11, 8'h44));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    // short word, t_len=1
    vecs.push_back(mk(1, 1, 32'hAABBCCDD, 1, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hDD, 8'hAA));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'hCC, 8'hBB));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    // single-beat word, t_len=0
    vecs.push_back(mk(1, 1, 32'h12345678, 0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'h78, 8'h12));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    // reset after beat 1, then a fresh word starts at beat 0
    vecs.push_back(mk(1, 1, 32'hAABBCCDD, 3, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hDD, 8'hAA));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'hCC, 8'hBB));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 32'h55667788, 3, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h88, 8'h55));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h77, 8'h66));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  0, 1, 0, 0, 1, 8'h66, 8'h77));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 1, 1, 1, 1, 8'h55, 8'h88));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00));

    // Drive just after each rising edge, check on the falling edge.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      rstf = v.rstf; t_valid = v.tv; t_data = v.td; t_len = v.tl; i_ready = v.ir;
      @(negedge clk);
      check_all(i, v);
    end

    // Asynchronous reset mid-cycle while a word is being sent.
    @(posedge clk); #1;
    t_valid = 1'b1; t_data = 32'hCAFEF00D; t_len = 2'd3; i_ready = 1'b0;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check_all(1000, mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 8'h0D, 8'hCA));
    #2 rstf = 1'b0;
    #1 check_all(1001, mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    @(posedge clk); #3;
    rstf = 1'b1; i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all(1002 + c, mk(1, 0, 0, 0, 1,  1, 0, 0, 0, 1, 8'h00, 8'h00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
